qspi_fifo_tx: RTL and testbench
===============================

Name: qspi_fifo_tx

Overview:
- Drains bytes from the read side of the TX FIFO and serialises them onto QSPI data lines in single (1-bit) or quad (4-bit) mode.
- Generates SCLK and CS_N, and sits between the read port of the TX FIFO (DELAY=1 mode, registered read data) and the QSPI pads.
- One transfer per start pulse, of a programmed byte count.

Parameters:
- DATA_WIDTH, 8, FIFO data width; fixed at 8, one byte per FIFO word.
- CNT_WIDTH, 8, width of byte_cnt; a transfer is at most 2^CNT_WIDTH-1 bytes.
- DIV_HALF, 2, SCLK half-period in clk cycles; must be at least 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- quad  input  1  0 = single mode on io_out[0]; 1 = quad mode on io_out[3:0]. Latched at start.
- byte_cnt  input  CNT_WIDTH  number of bytes; latched at start.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  DATA_WIDTH  FIFO read data, valid in the cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO pop.
- sclk  output  1  QSPI clock, SPI mode 0, idle low.
- cs_n  output  1  chip select, active low.
- io_out  output  4  data to pads.
- io_oe  output  4  pad output enables.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at transfer end.

Behaviour:
- Reset (any cycle, including mid-transfer):
  - Next state is IDLE.
  - sclk=0, cs_n=1, io_out=0, io_oe=0, fifo_rd_en=0, busy=0, done=0.
  - Shift register and counters are cleared.
- States are IDLE, FETCH, WAIT, SHIFT, FINISH, DONE. All outputs are registered except fifo_rd_en, which is combinational: (state==FETCH) && !fifo_empty.
- IDLE:
  - start=1 and byte_cnt!=0: latch quad and byte_cnt, cs_n<=0, busy<=1, go to FETCH.
  - start=1 and byte_cnt==0: go straight to DONE; cs_n stays 1 and the FIFO is not touched.
  - start while busy is ignored.
- FETCH:
  - If !fifo_empty, pop one byte and go to WAIT.
  - If empty, stall: hold sclk=0 and cs_n=0, io_out unchanged. There is no timeout.
- WAIT: capture fifo_rdata into the shift register, go to SHIFT.
- SHIFT, unit structure:
  - A byte is B units: B=8 in single mode, B=2 in quad mode.
  - Each unit lasts 2*DIV_HALF cycles: sclk=0 for the first DIV_HALF cycles, then sclk=1 for the next DIV_HALF.
  - io_out updates at the first cycle of each unit; the peripheral samples on the sclk rising edge.
- SHIFT, bit ordering:
  - Single mode: io_out[0] carries the byte MSB first; io_out[3:1]=0; io_oe=4'b0001.
  - Quad mode: high nibble first, with io_out[3] the nibble MSB; io_oe=4'b1111.
- SHIFT, exit after the last unit:
  - Decrement the remaining count.
  - If nonzero, go to FETCH; sclk stays low through FETCH and WAIT, giving a minimum inter-byte gap of 2 cycles.
  - If zero, go to FINISH.
- FINISH: sclk=0, cs_n=0 for DIV_HALF cycles, then go to DONE.
- DONE:
  - done=1 and cs_n=1; busy=0 in this same cycle; io_oe=0 and io_out=0.
  - Next cycle returns to IDLE.
  - A start asserted in the DONE cycle is ignored.
- Latency with the FIFO never empty, counting start sampled at cycle 0: done is high at cycle 1 + N*(2 + B*2*DIV_HALF) + DIV_HALF. Each stall cycle in FETCH adds 1.
- Counters:
  - Unit counter width is 3 bits; half-period counter width is $clog2(DIV_HALF)+1.
  - Remaining-byte counter is CNT_WIDTH wide and never wraps below 0.

Test Plan:
- DIV_HALF=2, single mode, byte_cnt=1, FIFO preloaded with 0xA5, start at cycle 0:
  - fifo_rd_en high only in cycle 1; cs_n low in cycles 1–36.
  - io_out[0] sequence 1,0,1,0,0,1,0,1, each value held 4 cycles starting at cycle 3.
  - 8 sclk rising edges; done=1 at cycle 37 only.
- DIV_HALF=1, quad mode, byte_cnt=2, FIFO holds 0x3C then 0x7E:
  - io_out nibbles 3,C,7,E; io_oe=4'b1111 during transfer.
  - done at cycle 14; exactly 2 pops.
- FIFO empty at start, then written at cycle 10, single mode, DIV_HALF=2, byte_cnt=1:
  - FETCH stalls with cs_n=0 and sclk=0, fifo_rd_en=0 in cycles 1–9.
  - Pop occurs in cycle 10 or later; done is delayed by the stall length; byte data is correct.
- byte_cnt=0 with start:
  - done pulses at cycle 1; cs_n stays 1 throughout.
  - No fifo_rd_en; no sclk edges.
- rst asserted mid-SHIFT, byte_cnt=3:
  - Next cycle: cs_n=1, sclk=0, io_oe=0, busy=0, no done pulse.
  - A new start afterwards transfers correctly from the current FIFO head.
- start pulsed while busy, and again in the DONE cycle:
  - Both are ignored: no extra pops, byte counter unaffected.

Source files
------------

// File: rtl/qspi_fifo_tx.sv
// QSPI transmit engine: pops bytes from a registered-read FIFO and shifts them
// out on one or four data lines, framing the transfer with CS_N and SCLK (mode 0).
module qspi_fifo_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int DIV_HALF   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  quad,
    input  logic [CNT_WIDTH-1:0]  byte_cnt,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  sclk,
    output logic                  cs_n,
    output logic [3:0]            io_out,
    output logic [3:0]            io_oe,
    output logic                  busy,
    output logic                  done
);
    localparam int            HW    = $clog2(DIV_HALF) + 1;
    localparam logic [HW-1:0] HLAST = HW'(DIV_HALF - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, FINISH, DONE} state_t;

    state_t                 state;
    logic                   quad_q;
    logic [CNT_WIDTH-1:0]   rem;
    logic [DATA_WIDTH-1:0]  sh;
    logic [DATA_WIDTH-1:0]  sh_next;
    logic [2:0]             ucnt;
    logic [2:0]             ulast;
    logic [HW-1:0]          hcnt;

    // The next unit always comes from the top of the shift register.
    function automatic logic [3:0] unit_bits(input logic q, input logic [DATA_WIDTH-1:0] d);
        return q ? d[DATA_WIDTH-1 -: 4] : {3'b000, d[DATA_WIDTH-1]};
    endfunction

    assign fifo_rd_en = (state == FETCH) && !fifo_empty;
    assign ulast      = quad_q ? 3'd1 : 3'd7;
    assign sh_next    = quad_q ? (sh << 4) : (sh << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            quad_q <= 1'b0;
            rem    <= '0;
            sh     <= '0;
            ucnt   <= '0;
            hcnt   <= '0;
            sclk   <= 1'b0;
            cs_n   <= 1'b1;
            io_out <= '0;
            io_oe  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (byte_cnt != '0) begin
                            quad_q <= quad;
                            rem    <= byte_cnt;
                            cs_n   <= 1'b0;
                            busy   <= 1'b1;
                            io_oe  <= quad ? 4'b1111 : 4'b0001;
                            state  <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (!fifo_empty) state <= WAIT;
                end
                WAIT: begin
                    // Drive the first unit now so it is on the pads in the first SHIFT cycle.
                    sh     <= fifo_rdata;
                    io_out <= unit_bits(quad_q, fifo_rdata);
                    ucnt   <= '0;
                    hcnt   <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    if (hcnt != HLAST) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        hcnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (ucnt != ulast) begin
                                ucnt   <= ucnt + 3'd1;
                                sh     <= sh_next;
                                io_out <= unit_bits(quad_q, sh_next);
                            end else begin
                                rem   <= (rem != '0) ? rem - CNT_WIDTH'(1) : '0;
                                state <= (rem > CNT_WIDTH'(1)) ? FETCH : FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    if (hcnt != HLAST) begin
                        hcnt <= hcnt + HW'(1);
                    end else begin
                        hcnt   <= '0;
                        done   <= 1'b1;
                        cs_n   <= 1'b1;
                        busy   <= 1'b0;
                        io_oe  <= '0;
                        io_out <= '0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_fifo_tx.sv
// Scoreboard bench for qspi_fifo_tx: a FIFO model feeds the DUT, a monitor
// rebuilds bytes from sclk rising edges and checks them and done timing.
module tb_qspi_fifo_tx;
    localparam int DH = 2;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, quad = 1'b0;
    logic [7:0] byte_cnt = '0;
    logic       fifo_empty;
    logic [7:0] fifo_rdata = '0;
    logic       fifo_rd_en, sclk, cs_n, busy, done;
    logic [3:0] io_out, io_oe;

    qspi_fifo_tx #(.DATA_WIDTH(8), .CNT_WIDTH(8), .DIV_HALF(DH)) dut (
        .clk(clk), .rst(rst), .start(start), .quad(quad), .byte_cnt(byte_cnt),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .sclk(sclk), .cs_n(cs_n), .io_out(io_out), .io_oe(io_oe),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, pushed = 0, pops = 0;
    int rises = 0, cs_low = 0, done_cnt = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         exp_done_q[$];
    bit         exp_quad = 1'b0;

    assign fifo_empty = (pushed == pops);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat(input bit q, input int n);
        if (n == 0) return 1;
        return 1 + n * (2 + (q ? 2 : 8) * 2 * DH) + DH;
    endfunction

    task automatic push_fifo(input logic [7:0] b);
        fifo_q.push_back(b);
        pushed++;
    endtask

    // FIFO model: registered read data, one cycle after the pop.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
            pops <= pops + 1;
        end
    end

    // Monitor: rebuild bytes on sclk rising edges, check done timing.
    logic [7:0] mbyte = '0;
    int         mbits = 0;
    logic       sclk_d = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            mbits  = 0;
            sclk_d = 1'b0;
        end else begin
            if (!cs_n) cs_low++;
            if (sclk && !sclk_d) begin
                rises++;
                chk("cs_n_at_rise", {31'b0, cs_n}, 32'd0);
                if (exp_quad) begin
                    chk("io_oe_quad", {28'b0, io_oe}, 32'hF);
                    mbyte = {mbyte[3:0], io_out};
                    mbits += 4;
                end else begin
                    chk("io_oe_single", {25'b0, io_oe, io_out[3:1]}, 32'h08);
                    mbyte = {mbyte[6:0], io_out[0]};
                    mbits += 1;
                end
                if (mbits == 8) begin
                    mbits = 0;
                    if (exp_q.size() == 0) chk("unexpected_byte", {24'b0, mbyte}, 32'hFFFF_FFFF);
                    else chk("byte_data", {24'b0, mbyte}, {24'b0, exp_q.pop_front()});
                end
            end
            sclk_d = sclk;
            if (done) begin
                done_cnt++;
                chk("done_cs_n", {31'b0, cs_n}, 32'd1);
                chk("done_busy", {31'b0, busy}, 32'd0);
                if (exp_done_q.size() == 0) chk("unexpected_done", cyc, 32'hFFFF_FFFF);
                else chk("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
    end

    task automatic wait_done(input int budget, input bit poke_done);
        int t = 0;
        while (!done && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (!done) chk("done_timeout", t, budget + 1);
        else if (poke_done) begin
            start = 1'b1; byte_cnt = 8'd3;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic issue(input bit q, input int n, input int fill, input bit poke);
        int p0, r0, c0, k;
        for (int i = 0; i < fill; i++) push_fifo(8'($urandom_range(0, 255)));
        for (int i = 0; i < n && i < fifo_q.size(); i++) exp_q.push_back(fifo_q[i]);
        exp_quad = q;
        p0 = pops; r0 = rises; c0 = cs_low;
        @(negedge clk);
        start = 1'b1; quad = q; byte_cnt = 8'(n); k = cyc;
        exp_done_q.push_back(k + lat(q, n));
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            repeat (5) @(negedge clk);
            start = 1'b1; byte_cnt = 8'd5;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(lat(q, n) + 20, poke);
        repeat (4) @(negedge clk);
        chk("pop_count", pops - p0, n);
        chk("sclk_rises", rises - r0, n * (q ? 2 : 8));
        chk("cs_low_cycles", cs_low - c0, (n == 0) ? 0 : lat(q, n) - 1);
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int k, p0, c0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
        chk("rst_outs", {21'b0, sclk, io_out, io_oe, busy, done, fifo_rd_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single mode, one known byte.
        push_fifo(8'hA5);
        issue(1'b0, 1, 0, 1'b0);

        // Quad mode, two known bytes.
        push_fifo(8'h3C); push_fifo(8'h7E);
        issue(1'b1, 2, 0, 1'b0);

        // FIFO empty at start; byte arrives in cycle 10.
        exp_quad = 1'b0; p0 = pops; c0 = cs_low;
        @(negedge clk);
        start = 1'b1; quad = 1'b0; byte_cnt = 8'd1; k = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            chk("stall_outs", {29'b0, fifo_rd_en, cs_n, sclk}, 32'd0);
            @(negedge clk);
        end
        push_fifo(8'h96);
        exp_q.push_back(8'h96);
        exp_done_q.push_back(k + lat(1'b0, 1) + 9);
        wait_done(lat(1'b0, 1) + 20, 1'b0);
        repeat (2) @(negedge clk);
        chk("stall_pops", pops - p0, 1);
        chk("stall_cs_low", cs_low - c0, lat(1'b0, 1) + 8);

        // Zero-length transfer leaves a byte in the FIFO untouched.
        issue(1'b0, 0, 1, 1'b0);

        // Reset in the middle of a shift, then resume from the FIFO head.
        for (int i = 0; i < 3; i++) push_fifo(8'($urandom_range(0, 255)));
        exp_quad = 1'b0;
        @(negedge clk);
        start = 1'b1; quad = 1'b0; byte_cnt = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", {31'b0, cs_n}, 32'd1);
        chk("midrst_outs", {25'b0, sclk, io_oe, busy, done}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        issue(1'b0, 2, 0, 1'b0);

        // Starts while busy and in the DONE cycle are ignored.
        issue(1'b1, 2, 4, 1'b1);

        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 3);
            issue(1'($urandom_range(0, 1)), n, n, 1'b0);
        end

        chk("exp_bytes_left", exp_q.size(), 0);
        chk("exp_done_left", exp_done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
